cam_array: RTL and testbench
============================

# cam_array

Parametrised content-addressable memory: DEPTH entries of WIDTH bits, each with its own valid bit. It supports a multi-cycle initialisation sequence and four key-based operations: lookup, replace-all-matches, write-at-address and invalidate-matches. Each accepted operation returns registered match results one cycle later: hit, lowest and highest matching address, and match count. It is the next-generation lookup CAM, used wherever the design needs key-to-slot resolution.

## Interface
Parameters:
- WIDTH, 4, entry/key width in bits (>=1)
- DEPTH, 8, number of entries (>=2)
- INIT_BASE, 8, init value of entry i is (INIT_BASE + i) truncated to WIDTH
- AW, derived = $clog2(DEPTH), address width (not overridable)
- CW, derived = $clog2(DEPTH+1), match-count width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- init  in  1  start/restart the init sequence
- busy  out  1  high while the init sequence runs
- op_valid  in  1  operation request
- op_ready  out  1  = (state==IDLE) && !init
- op_code  in  2  00 LOOKUP, 01 REPLACE, 10 WRITE, 11 INVALIDATE
- key  in  WIDTH  match key (all ops)
- new_data  in  WIDTH  write data (REPLACE, WRITE)
- wr_addr  in  AW  target entry (WRITE only)
- res_valid  out  1  one-cycle pulse, results valid
- hit  out  1  at least one valid entry matched
- min_addr  out  AW  lowest matching index
- max_addr  out  AW  highest matching index
- match_count  out  CW  number of matching valid entries

## Operation
- Storage: data[DEPTH][WIDTH] plus vld[DEPTH]. Entry i matches when vld[i] && data[i]==key.
- FSM states: IDLE and INIT.
  - IDLE -> INIT on init=1. The counter is cleared and busy is asserted.
  - INIT: each cycle, write data[cnt] = INIT_BASE+cnt and set vld[cnt]=1, then cnt++. After cnt reaches DEPTH-1, return to IDLE.
  - init=1 while in INIT restarts the counter at 0.
  - Entries not yet reached keep their previous contents.
- An op is accepted on an edge where op_valid && op_ready. The match vector is computed from the contents present before that edge.
  - LOOKUP: no state change.
  - REPLACE: data[i] = new_data for every matching i. vld is unchanged.
  - WRITE: data[wr_addr] = new_data and vld[wr_addr] = 1. If wr_addr >= DEPTH, no write occurs.
  - INVALIDATE: vld[i] = 0 for every matching i.
- Results always describe the pre-operation match of key, whatever the op_code.
- No match: hit=0, min_addr=0, max_addr=0, match_count=0.
- init and op_valid in the same cycle: init wins and the op is not accepted. The requester must hold the op.
- Ops issued while busy are not accepted, and no res_valid is produced for them.

## Timing
- Reset (rst_n=0, asynchronous):
  - all vld=0, all data=0, state IDLE
  - busy=0, res_valid=0, hit=0, min_addr=0, max_addr=0, match_count=0
  - op_ready follows its equation (1 when init=0)
- Result latency: exactly 1 cycle. For an op accepted at edge N, res_valid=1 during cycle N..N+1 with results registered at edge N. The writes from that op also land at edge N.
- Result fields hold their last value when res_valid=0.
- Back-to-back ops are allowed every cycle. Op k+1 sees all writes of op k.
- Init duration: busy=1 for exactly DEPTH cycles after the edge that samples init. op_ready=0 throughout.
- A reset asserted mid-init aborts immediately, with partially loaded entries cleared. After deassertion the block is in IDLE.

## Test plan
All scenarios use WIDTH=4, DEPTH=8, INIT_BASE=8.
- After reset, LOOKUP key=0 -> res_valid next cycle, hit=0, count=0 (zeroed data is invalid).
- Pulse init -> busy=1 for 8 cycles and op_ready=0. Then LOOKUP 0xA -> hit=1, min=max=2, count=1. LOOKUP 0x7 -> hit=0.
- WRITE addr=5 data=0xA, then LOOKUP 0xA -> hit=1, min=2, max=5, count=2. WRITE addr=7 data=0x0 with key=0xF -> result hit=1, min=max=7, count=1 (pre-write).
- REPLACE key=0xA new=0x3 -> result min=2, max=5, count=2. Next-cycle LOOKUP 0x3 -> min=2, max=5, count=2. LOOKUP 0xA -> hit=0.
- Back-to-back INVALIDATE 0x3 then LOOKUP 0x3 on consecutive cycles -> first result count=2, second result hit=0, count=0.
- Assert rst_n=0 four cycles into init -> busy drops at once and all outputs are 0. Assert init and op_valid together in IDLE -> op_ready=0, no res_valid, busy=1 on the next cycle.

Source files
------------

// File: rtl/cam_array.sv
// cam_array: parametrised content-addressable memory with per-entry valid bits.
//
// Entries are loaded by an init sequence, then queried and modified by key-based
// operations. Each accepted operation returns registered match results one
// cycle later. These results always describe the match before the operation's
// own writes are applied.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   init         start/restart the init sequence (wins over op_valid)
//   busy         high while the init sequence runs
//   op_valid     operation request
//   op_ready     (state == IDLE) && !init
//   op_code      00 LOOKUP, 01 REPLACE, 10 WRITE, 11 INVALIDATE
//   key          match key (all ops)
//   new_data     write data (REPLACE, WRITE)
//   wr_addr      target entry (WRITE only)
//   res_valid    one-cycle pulse, result fields valid
//   hit          at least one valid entry matched
//   min_addr     lowest matching index (0 when no match)
//   max_addr     highest matching index (0 when no match)
//   match_count  number of matching valid entries
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | accepting operations (op_ready when init is low)
// INIT   | loading entry cnt with INIT_BASE+cnt each cycle, DEPTH cycles
module cam_array #(
    parameter  int WIDTH     = 4,
    parameter  int DEPTH     = 8,
    parameter  int INIT_BASE = 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] new_data,
    input  logic [AW-1:0]    wr_addr,
    output logic             res_valid,
    output logic             hit,
    output logic [AW-1:0]    min_addr,
    output logic [AW-1:0]    max_addr,
    output logic [CW-1:0]    match_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_INIT = 1'b1;

    localparam logic [1:0] OP_LOOKUP     = 2'b00;
    localparam logic [1:0] OP_REPLACE    = 2'b01;
    localparam logic [1:0] OP_WRITE      = 2'b10;
    localparam logic [1:0] OP_INVALIDATE = 2'b11;

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    logic [0:0]       state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic [DEPTH-1:0] match;
    logic             match_any;
    logic [AW-1:0]    match_min;
    logic [AW-1:0]    match_max;
    logic [CW-1:0]    match_cnt;
    logic             accept;
    logic             init_wr;
    logic             wr_in_range;
    logic [WIDTH-1:0] init_val;

    assign busy     = (state == ST_INIT);
    assign op_ready = (state == ST_IDLE) && !init;
    assign accept   = op_valid && op_ready;

    // A restart request during INIT resets the counter instead of loading.
    assign init_wr  = (state == ST_INIT) && !init;
    assign init_val = WIDTH'(INIT_BASE + int'(cnt));

    // Only meaningful when DEPTH is not a power of two.
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = vld_q[i] && (data_q[i] == key);
        end
    end

    // Lowest match wins min (first hit); highest match wins max (last hit).
    always_comb begin
        match_any = 1'b0;
        match_min = '0;
        match_max = '0;
        match_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                if (!match_any) begin
                    match_min = AW'(i);
                end
                match_any = 1'b1;
                match_max = AW'(i);
            end
            match_cnt = match_cnt + CW'(match[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                ST_INIT: begin
                    if (init) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Init loading and op writes are mutually exclusive: ops are only
    // accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
        end else if (init_wr) begin
            data_q[cnt] <= init_val;
            vld_q[cnt]  <= 1'b1;
        end else if (accept) begin
            case (op_code)
                OP_REPLACE: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (match[i]) begin
                            data_q[i] <= new_data;
                        end
                    end
                end
                OP_WRITE: begin
                    if (wr_in_range) begin
                        data_q[wr_addr] <= new_data;
                        vld_q[wr_addr]  <= 1'b1;
                    end
                end
                OP_INVALIDATE: begin
                    vld_q <= vld_q & ~match;
                end
                OP_LOOKUP: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Result fields hold their last value between accepted ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            hit         <= 1'b0;
            min_addr    <= '0;
            max_addr    <= '0;
            match_count <= '0;
        end else begin
            res_valid <= accept;
            if (accept) begin
                hit         <= match_any;
                min_addr    <= match_min;
                max_addr    <= match_max;
                match_count <= match_cnt;
            end
        end
    end

endmodule

// File: tb/tb_cam_array.sv
module tb_cam_array;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int INIT_BASE = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    localparam logic [1:0] LOOKUP = 2'b00;
    localparam logic [1:0] REPLACE = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] INVAL = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             init;
    logic             busy;
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] new_data;
    logic [AW-1:0]    wr_addr;
    logic             res_valid;
    logic             hit;
    logic [AW-1:0]    min_addr;
    logic [AW-1:0]    max_addr;
    logic [CW-1:0]    match_count;

    cam_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_BASE(INIT_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .busy(busy),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .key(key), .new_data(new_data), .wr_addr(wr_addr),
        .res_valid(res_valid), .hit(hit), .min_addr(min_addr),
        .max_addr(max_addr), .match_count(match_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Reference contents of the CAM.
    logic [WIDTH-1:0] m_data [DEPTH];
    logic             m_vld [DEPTH];
    // {hit, min, max, count} of the most recent accepted op.
    logic [10:0]      last_res;

    function automatic logic [10:0] model_result(input logic [WIDTH-1:0] k);
        int q[$];
        for (int i = 0; i < DEPTH; i++)
            if (m_vld[i] && m_data[i] == k) q.push_back(i);
        if (q.size() == 0) return 11'd0;
        return {1'b1, 3'(q[0]), 3'(q[q.size()-1]), 4'(q.size())};
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_vld[i] = 1'b0;
        end
    endfunction

    function automatic void model_apply(input logic [1:0] code, input logic [3:0] k,
                                        input logic [3:0] nd, input logic [2:0] a);
        logic hitv [DEPTH];
        for (int i = 0; i < DEPTH; i++) hitv[i] = m_vld[i] && m_data[i] == k;
        case (code)
            REPLACE: for (int i = 0; i < DEPTH; i++) if (hitv[i]) m_data[i] = nd;
            WRITE: begin m_data[a] = nd; m_vld[a] = 1'b1; end
            INVAL: for (int i = 0; i < DEPTH; i++) if (hitv[i]) m_vld[i] = 1'b0;
            default: ;
        endcase
    endfunction

    // Presents one op (left asserted for back-to-back use) and checks its result.
    task automatic issue(input logic [1:0] code, input logic [3:0] k,
                         input logic [3:0] nd, input logic [2:0] a);
        logic [10:0] e;
        e = model_result(k);
        op_valid = 1'b1; op_code = code; key = k; new_data = nd; wr_addr = a;
        #1;
        n_checks++;
        if (op_ready !== 1'b1)
            $display("FAIL issue_ready: op_ready=%b expected 1", op_ready);
        else n_pass++;
        model_apply(code, k, nd, a);
        @(posedge clk); #1;
        n_checks++;
        if ({res_valid, hit, min_addr, max_addr, match_count} !== {1'b1, e})
            $display("FAIL op_result code=%0d key=%h: got v=%b hit=%b min=%0d max=%0d cnt=%0d expected v=1 hit=%b min=%0d max=%0d cnt=%0d",
                     code, k, res_valid, hit, min_addr, max_addr, match_count,
                     e[10], e[9:7], e[6:4], e[3:0]);
        else n_pass++;
        last_res = e;
    endtask

    task automatic idle(input int n);
        op_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            n_checks++;
            if ({res_valid, hit, min_addr, max_addr, match_count} !== {1'b0, last_res})
                $display("FAIL idle_hold: got v=%b fields=%h expected v=0 fields=%h",
                         res_valid, {hit, min_addr, max_addr, match_count}, last_res);
            else n_pass++;
        end
    endtask

    // Pulses init for one cycle and checks busy/op_ready over the DEPTH-cycle load.
    task automatic run_init();
        init = 1'b1;
        #1;
        n_checks++;
        if (op_ready !== 1'b0) $display("FAIL init_ready_low: op_ready=%b expected 0", op_ready);
        else n_pass++;
        @(posedge clk); #1;
        init = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if ({busy, op_ready, res_valid} !== 3'b100)
                $display("FAIL init_busy cyc=%0d: busy=%b ready=%b rv=%b expected 1 0 0",
                         i, busy, op_ready, res_valid);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if ({busy, op_ready} !== 2'b01)
            $display("FAIL init_done: busy=%b ready=%b expected 0 1", busy, op_ready);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = 4'(INIT_BASE + i);
            m_vld[i] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init = 1'b0; op_valid = 1'b0;
        op_code = '0; key = '0; new_data = '0; wr_addr = '0;
        model_clear();
        last_res = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, op_ready, res_valid, hit, min_addr, max_addr, match_count} !== 14'b01_000000000000)
            $display("FAIL reset_state: busy=%b ready=%b rv=%b hit=%b min=%0d max=%0d cnt=%0d expected ready=1 rest 0",
                     busy, op_ready, res_valid, hit, min_addr, max_addr, match_count);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue(LOOKUP, 4'h0, 4'h0, 3'd0);
        idle(1);
    endtask

    task automatic test_init();
        run_init();
        issue(LOOKUP, 4'hA, 4'h0, 3'd0);
        issue(LOOKUP, 4'h7, 4'h0, 3'd0);
        idle(1);
    endtask

    task automatic test_write();
        issue(WRITE, 4'h7, 4'hA, 3'd5);
        issue(LOOKUP, 4'hA, 4'h0, 3'd0);
        issue(WRITE, 4'hF, 4'h0, 3'd7);
        issue(LOOKUP, 4'hF, 4'h0, 3'd0);
        issue(LOOKUP, 4'h0, 4'h0, 3'd0);
        idle(2);
    endtask

    task automatic test_replace();
        issue(REPLACE, 4'hA, 4'h3, 3'd0);
        issue(LOOKUP, 4'h3, 4'h0, 3'd0);
        issue(LOOKUP, 4'hA, 4'h0, 3'd0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        issue(INVAL, 4'h3, 4'h0, 3'd0);
        issue(LOOKUP, 4'h3, 4'h0, 3'd0);
        issue(WRITE, 4'h1, 4'h9, 3'd0);
        issue(LOOKUP, 4'h9, 4'h0, 3'd0);
        idle(1);
    endtask

    task automatic test_reset_mid_init();
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        last_res = '0;
        n_checks++;
        if ({busy, op_ready, res_valid, hit, min_addr, max_addr, match_count} !== 14'b01_000000000000)
            $display("FAIL mid_init_reset: busy=%b ready=%b rv=%b hit=%b min=%0d max=%0d cnt=%0d expected ready=1 rest 0",
                     busy, op_ready, res_valid, hit, min_addr, max_addr, match_count);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue(LOOKUP, 4'h8, 4'h0, 3'd0);
        issue(LOOKUP, 4'h0, 4'h0, 3'd0);
        idle(1);
    endtask

    task automatic test_init_op_collision();
        init = 1'b1; op_valid = 1'b1; op_code = WRITE; key = 4'h0;
        new_data = 4'h5; wr_addr = 3'd1;
        #1;
        n_checks++;
        if (op_ready !== 1'b0) $display("FAIL collide_ready: op_ready=%b expected 0", op_ready);
        else n_pass++;
        @(posedge clk); #1;
        init = 1'b0; op_valid = 1'b0;
        n_checks++;
        if ({res_valid, busy} !== 2'b01)
            $display("FAIL collide_result: rv=%b busy=%b expected 0 1", res_valid, busy);
        else n_pass++;
        repeat (DEPTH) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = 4'(INIT_BASE + i);
            m_vld[i] = 1'b1;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL collide_init_end: busy=%b expected 0", busy);
        else n_pass++;
        issue(LOOKUP, 4'h9, 4'h0, 3'd0);
        issue(LOOKUP, 4'h5, 4'h0, 3'd0);
        idle(1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            issue(c, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(1);
        run_init();
        for (int n = 0; n < 40; n++)
            issue(LOOKUP, 4'($urandom_range(0, 15)), 4'h0, 3'd0);
        idle(1);
    endtask

    initial begin
        test_reset();
        test_init();
        test_write();
        test_replace();
        test_back_to_back();
        test_reset_mid_init();
        test_init_op_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
